bus_resp_8086: RTL

BUS_RESP_8086 -- requirements
Module: bus_resp_8086

---
 rtl/bus_resp_8086.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bus_resp_8086.sv
// 8086 minimum-mode bus slave: decodes a latched address window and bridges
// the cycle to a simple req/ack local memory port. `BUS_RESP_TIMEOUT_EN adds an ACCESS timeout.
module bus_resp_8086 #(
  parameter logic [19:0] BASE_ADDR = 20'h00000,
  parameter logic [19:0] ADDR_MASK = 20'hF0000,
  parameter bit          IO_SPACE  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ale,
  input  logic [15:0] addr_data_in,
  input  logic [3:0]  addr_status_n,
  input  logic        bhe_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m_io_n,
  input  logic        den_n,
  output logic [15:0] addr_data_out,
  output logic        addr_data_oe,
  output logic        ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_LATCHED, S_ACCESS, S_RDRIVE, S_WHOLD} state_e;

  state_e      state_q, state_d;
  logic [19:0] lat_addr_q, lat_addr_d;
  logic        lat_bhe_n_q, lat_bhe_n_d;
  logic        lat_mio_q, lat_mio_d;
  logic        mem_we_q, mem_we_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        sel;
  logic [1:0]  lane_be;
  logic        timeout;

  assign sel     = (((lat_addr_q ^ BASE_ADDR) & ADDR_MASK) == 20'h0) && (lat_mio_q == !IO_SPACE);
  assign lane_be = {~lat_bhe_n_q, ~lat_addr_q[0]};

`ifdef BUS_RESP_TIMEOUT_EN
  logic [6:0] cnt_q, cnt_d;
  // cnt_q holds (ACCESS cycle number - 1), so the 64th cycle sees 63.
  assign timeout = (state_q == S_ACCESS) && !mem_ack && (cnt_q == 7'd63);
  assign cnt_d   = (state_q == S_ACCESS) ? cnt_q + 7'd1 : 7'd0;
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= 7'd0;
    else      cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    lat_addr_d  = lat_addr_q;
    lat_bhe_n_d = lat_bhe_n_q;
    lat_mio_d   = lat_mio_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE, S_LATCHED: begin
        if (ale) begin
          lat_addr_d  = {addr_status_n, addr_data_in};
          lat_bhe_n_d = bhe_n;
          lat_mio_d   = m_io_n;
          state_d     = S_LATCHED;
        end else if (state_q == S_LATCHED) begin
          if (!sel) begin
            state_d = S_IDLE;
          end else if (!rd_n || !wr_n) begin
            // A read strobe wins when both strobes are low.
            mem_we_d   = rd_n;
            mem_addr_d = lat_addr_q[19:1];
            mem_be_d   = lane_be;
            if (rd_n) mem_wdata_d = addr_data_in;
            if (lane_be == 2'b00) begin
              rdata_d = 16'hFFFF;
              state_d = rd_n ? S_WHOLD : S_RDRIVE;
            end else begin
              state_d = S_ACCESS;
            end
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          if (!mem_we_q) rdata_d = mem_rdata;
          state_d = mem_we_q ? S_WHOLD : S_RDRIVE;
        end else if (timeout) begin
          rdata_d = 16'hFFFF;
          state_d = mem_we_q ? S_WHOLD : S_RDRIVE;
        end
      end
      S_RDRIVE: if (rd_n) state_d = S_IDLE;
      S_WHOLD:  if (wr_n) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lat_addr_q  <= 20'h0;
      lat_bhe_n_q <= 1'b1;
      lat_mio_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 19'h0;
      mem_be_q    <= 2'b00;
      mem_wdata_q <= 16'h0;
      rdata_q     <= 16'h0;
    end else begin
      state_q     <= state_d;
      lat_addr_q  <= lat_addr_d;
      lat_bhe_n_q <= lat_bhe_n_d;
      lat_mio_q   <= lat_mio_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_req       = (state_q == S_ACCESS);
  assign ready         = !mem_req;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;
  assign addr_data_oe  = (state_q == S_RDRIVE) && !rd_n && !den_n;
  assign addr_data_out = addr_data_oe ? rdata_q : 16'h0000;
  assign bus_err       = timeout;
  assign dbg_state     = state_q;

endmodule
